// File: rtl/grad_dir_arbiter.sv
// grad_dir_arbiter: several Sobel pixel lanes share one gradient-direction
// quantizer. A round-robin arbiter picks one lane per cycle. Its Gx/Gy pair
// goes through a capture register (s1) and then a quantize+response register
// (s2). Each response carries a 2-bit direction code and the lane id.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready per-lane handshake (req_ready is combinational, one-hot or zero)
//   req_gx/req_gy       packed signed gradients, lane i at [i*GW +: GW]
//   rsp_valid/rsp_ready response handshake
//   rsp_id              lane that issued the response
//   rsp_angle           0=0deg, 1=45deg, 2=90deg, 3=135deg
//   rsp_mag             |Gx|+|Gy| (only when GRAD_MAG_EN is defined)
//
// Build option: define GRAD_MAG_EN to add the rsp_mag output and its abs/adder logic.

module grad_dir_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned GW      = 11,
    parameter int unsigned IDW     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*GW-1:0]   req_gx,
    input  logic [NUM_REQ*GW-1:0]   req_gy,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [1:0]              rsp_angle
`ifdef GRAD_MAG_EN
    ,
    output logic [GW:0]             rsp_mag
`endif
);

    localparam int unsigned XW = GW + 1;

    // State registers
    logic                   s1_valid_q, s1_valid_d;
    logic [IDW-1:0]         s1_id_q,    s1_id_d;
    logic [GW-1:0]          s1_gx_q,    s1_gx_d;
    logic [GW-1:0]          s1_gy_q,    s1_gy_d;
    logic [IDW-1:0]         ptr_q,      ptr_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]         rsp_id_q,    rsp_id_d;
    logic [1:0]             rsp_angle_q, rsp_angle_d;
`ifdef GRAD_MAG_EN
    logic [XW-1:0]          rsp_mag_q,   rsp_mag_d;
`endif

    // Combinational helpers
    logic                   s2_load;
    logic                   s1_free;
    logic                   gnt_found;
    logic [IDW-1:0]         gnt_idx;
    logic                   xfer;
    logic signed [XW-1:0]   gx_e, gy_e, gx_n, gy_n;
    logic [1:0]             angle;
`ifdef GRAD_MAG_EN
    logic [XW-1:0]          abs_gx, abs_gy, mag;
`endif

    // Lane index (base + off) wrapped into 0..NUM_REQ-1
    function automatic logic [IDW-1:0] lane_at(input logic [IDW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDW'(s);
    endfunction

    // Stall rules
    always_comb begin
        s2_load = s1_valid_q & (~rsp_valid_q | rsp_ready);
        s1_free = ~s1_valid_q | s2_load;
    end

    // Round-robin search: first valid lane at or after the pointer
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && req_valid[lane_at(ptr_q, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = lane_at(ptr_q, k);
            end
        end
        req_ready = '0;
        if (gnt_found && s1_free) begin
            req_ready[gnt_idx] = 1'b1;
        end
        xfer = gnt_found & s1_free;
    end

    // Direction quantizer on s1; extended to GW+1 bits so -(-2^(GW-1)) is exact
    always_comb begin
        gx_e  = {s1_gx_q[GW-1], s1_gx_q};
        gy_e  = {s1_gy_q[GW-1], s1_gy_q};
        gx_n  = -gx_e;
        gy_n  = -gy_e;
        angle = 2'd0;
        if (gx_e == '0 && gy_e == '0) begin
            angle = 2'd0;
        end else if (gx_e == '0) begin
            angle = 2'd2;
        end else if (gy_e == '0) begin
            angle = 2'd0;
        end else if (!gx_e[XW-1] && !gy_e[XW-1]) begin
            angle = (gy_e > gx_e) ? 2'd1 : 2'd0;
        end else if (gx_e[XW-1] && gy_e[XW-1]) begin
            // Tie in this quadrant resolves to 45deg
            angle = (gy_e > gx_e) ? 2'd0 : 2'd1;
        end else if (!gx_e[XW-1]) begin
            angle = (gy_n > gx_e) ? 2'd3 : 2'd0;
        end else begin
            angle = (gy_e > gx_n) ? 2'd3 : 2'd0;
        end
    end

`ifdef GRAD_MAG_EN
    // |gx|+|gy| without saturation; max 2^GW fits in GW+1 bits
    always_comb begin
        abs_gx = gx_e[XW-1] ? XW'(gx_n) : XW'(gx_e);
        abs_gy = gy_e[XW-1] ? XW'(gy_n) : XW'(gy_e);
        mag    = abs_gx + abs_gy;
    end
`endif

    // Next-state logic for s1, pointer and s2
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_id_d     = s1_id_q;
        s1_gx_d     = s1_gx_q;
        s1_gy_d     = s1_gy_q;
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_angle_d = rsp_angle_q;
`ifdef GRAD_MAG_EN
        rsp_mag_d   = rsp_mag_q;
`endif
        if (xfer) begin
            s1_valid_d = 1'b1;
            s1_id_d    = gnt_idx;
            s1_gx_d    = req_gx[32'(gnt_idx) * GW +: GW];
            s1_gy_d    = req_gy[32'(gnt_idx) * GW +: GW];
            ptr_d      = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        if (s2_load) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = s1_id_q;
            rsp_angle_d = angle;
`ifdef GRAD_MAG_EN
            rsp_mag_d   = mag;
`endif
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_gx_q     <= '0;
            s1_gy_q     <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_angle_q <= 2'd0;
`ifdef GRAD_MAG_EN
            rsp_mag_q   <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_gx_q     <= s1_gx_d;
            s1_gy_q     <= s1_gy_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_angle_q <= rsp_angle_d;
`ifdef GRAD_MAG_EN
            rsp_mag_q   <= rsp_mag_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_angle = rsp_angle_q;
`ifdef GRAD_MAG_EN
    assign rsp_mag   = rsp_mag_q;
`endif

endmodule

// File: doc/grad_dir_arbiter.md
Name: grad_dir_arbiter

Overview:
- Shares one gradient-direction quantizer between NUM_REQ Sobel pixel lanes in the Canny pipeline.
- Round-robin arbitration selects one requester per cycle. Its Gx/Gy pair passes through a 2-stage pipeline: capture register, then quantize plus response register.
- Each response carries the 2-bit direction code and the requester id; the non-max-suppression stage consumes it.

Parameters:
- NUM_REQ, 4, number of requester lanes (2..8)
- GW, 11, signed gradient width
- IDW, 2, rsp_id width, equal to clog2(NUM_REQ)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-lane request valid
- req_ready  out  NUM_REQ  per-lane accept; at most one bit high per cycle
- req_gx  in  NUM_REQ*GW  packed signed Gx; lane i occupies bits [i*GW +: GW]
- req_gy  in  NUM_REQ*GW  packed signed Gy, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  downstream accept
- rsp_id  out  IDW  lane that issued the response
- rsp_angle  out  2  direction code: 0=0deg, 1=45deg, 2=90deg, 3=135deg
- rsp_mag  out  GW+1  |Gx|+|Gy|; present only with GRAD_MAG_EN

Behaviour:
- Reset: all flops update on the rising edge of clk while rst_n==0.
  - rsp_valid=0, rsp_id=0, rsp_angle=0, rsp_mag=0.
  - s1_valid=0, round-robin pointer=0, req_ready=0.
- Stage 1 capture register (s1): s1_valid, s1_id, s1_gx, s1_gy.
- Stage 2 response register (s2): drives the rsp_* outputs.
- Stall rules:
  - s2_load = s1_valid & (~rsp_valid | rsp_ready).
  - s1_free = ~s1_valid | s2_load.
- Arbitration (combinational):
  - Among asserted req_valid, grant the first lane at or after the pointer, searching upward modulo NUM_REQ.
  - req_ready[g] = s1_free for the granted lane g only; all other bits are 0.
  - req_ready may depend combinationally on req_valid. A requester must not make req_valid depend on req_ready.
- Handshake: a transfer occurs when req_valid[g] & req_ready[g].
  - s1 captures the lane's gx, gy and id g.
  - The pointer becomes (g+1) mod NUM_REQ.
  - The pointer is unchanged on cycles with no transfer.
- Stage 2 load: when s2_load, s2 takes the quantized s1 data and rsp_valid=1.
  - If rsp_valid & rsp_ready and there is no s2_load, rsp_valid drops to 0.
  - Outputs hold stable while rsp_valid & ~rsp_ready.
- Latency and throughput:
  - Accept at cycle N gives rsp_valid at cycle N+2.
  - Sustained throughput is 1 per cycle when rsp_ready is held high.
  - Simultaneous s1 drain and new capture in the same cycle is allowed.
- Quantizer rule (arc_tan instance on s1_gx/s1_gy), evaluated in order:
  - gx==0 & gy==0 -> 0.
  - gx==0 -> 2.
  - gy==0 -> 0.
  - gx>0 & gy>0: gy>gx -> 1, else 0.
  - gx<0 & gy<0: gy>gx -> 0, else 1. Note the tie case gives 1 here.
  - gx>0 & gy<0: -gy>gx -> 3, else 0.
  - gx<0 & gy>0: gy>-gx -> 3, else 0.
- Boundary conditions:
  - No requests: req_ready=0 and the pointer holds.
  - s1 full and s2 stalled: all req_ready=0.
  - Single requester: it is granted every cycle s1_free is high.
  - Gx=-1024 is legal; negation is computed at width GW+1.
  - Reset mid-operation: in-flight s1/s2 data is discarded with no response, and the pointer returns to 0.

Optional Feature:
- Macro: GRAD_MAG_EN.
- Defined:
  - Adds port rsp_mag (GW+1 bits), registered alongside rsp_angle.
  - Value is |gx|+|gy| as unsigned with no saturation; maximum 2048.
  - Reset value is 0.
- Not defined:
  - rsp_mag port is absent.
  - No abs/adder logic is built.
  - All other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low 2 cycles, no req -> rsp_valid=0, req_ready=0000; first grant after reset goes to lane 0 if valid.
- Round-robin, all 4 lanes valid, rsp_ready=1:
  - Grants go 0,1,2,3,0; one req_ready bit per cycle.
  - rsp_id sequence 0,1,2,3 starting 2 cycles after the first accept.
- Quantizer corners through lane 2:
  - (gx,gy) = (0,0) -> 0; (0,-5) -> 2; (7,0) -> 0.
  - (3,9) -> 1; (9,9) -> 0; (-9,-9) -> 1; (-3,-9) -> 1.
  - (5,-9) -> 3; (-9,5) -> 0; (-1024,1023) -> 0.
- Backpressure: lanes 0 and 1 valid, rsp_ready=0 for 5 cycles.
  - The first response holds stable with rsp_id=0.
  - s1 holds lane 1; all req_ready=0 after 2 accepts.
  - On rsp_ready=1, both drain in order 0,1 with no loss or duplication.
- Reset mid-stream: assert rst_n=0 while s1 and s2 are full -> next cycle rsp_valid=0; pointer restarts at lane 0.
- GRAD_MAG_EN build: (gx,gy)=(-1024,-1024) -> rsp_mag=2048, rsp_angle=1; (5,-9) -> rsp_mag=14.
